// File: rtl/merge_pkg.sv
// Shared definitions for the merging-stage FIFO write controller:
// output word layout, FSM state encoding and channel-ID field sizing.
package merge_pkg;

    localparam int WORD_W    = 32;
    localparam int CH_ID_MSB = WORD_W - 1;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_WAIT  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    // Channel ID occupies every bit above the timestamp field.
    function automatic int ch_id_width(input int ts_width);
        return WORD_W - ts_width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, wrapping, reported as one-hot grant plus encoded index.
module rr_arbiter #(
    parameter int N_CH  = 4,
    parameter int PTR_W = 2
) (
    input  logic             i_en,
    input  logic [N_CH-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_CH-1:0]  o_grant,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_valid
);

    logic [PTR_W:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_pos = {1'b0, i_ptr} + (PTR_W+1)'(k);
            if (w_pos >= (PTR_W+1)'(N_CH)) begin
                w_pos = w_pos - (PTR_W+1)'(N_CH);
            end
            if (i_en && !o_valid && i_req[w_pos[PTR_W-1:0]]) begin
                o_valid = 1'b1;
                o_idx   = w_pos[PTR_W-1:0];
                o_grant = N_CH'(1) << w_pos[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/merge_write_arbiter.sv
// Write-side controller for the merging FIFO: runs the FIFO reset/recovery
// window, then round-robin merges per-channel timestamps into one write port.
module merge_write_arbiter
    import merge_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int TS_WIDTH        = 28,
    parameter int RST_CYCLES      = 5,
    parameter int RST_WAIT_CYCLES = 8,
    parameter int DROP_CNT_WIDTH  = 16
) (
    input  logic                      Wclk,
    input  logic                      rst,
    input  logic [N_CH-1:0]           ch_valid,
    input  logic [N_CH*TS_WIDTH-1:0]  ch_data,
    input  logic                      fifo_full,
    input  logic                      fifo_almost_full,
    input  logic                      fifo_write_err,
    input  logic                      clr_status,
    output logic                      fifo_rst,
    output logic                      fifo_wr_en,
    output logic [WORD_W-1:0]         fifo_data,
    output logic                      ready,
    output logic [DROP_CNT_WIDTH-1:0] drop_count,
    output logic [N_CH-1:0]           ch_overflow,
    output logic                      wr_err_sticky
);

    localparam int PTR_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CHW    = ch_id_width(TS_WIDTH);
    localparam int MAXCNT = (RST_CYCLES > RST_WAIT_CYCLES) ? RST_CYCLES : RST_WAIT_CYCLES;
    localparam int CNT_W  = $clog2(MAXCNT + 1);

    state_t                    r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_fifo_rst;
    logic [N_CH-1:0]           r_hold_valid;
    logic [TS_WIDTH-1:0]       r_hold_data [N_CH];
    logic [PTR_W-1:0]          r_ptr;
    logic                      r_wr_en;
    logic [WORD_W-1:0]         r_data;
    logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;
    logic [N_CH-1:0]           r_ovf;
    logic                      r_err;

    logic                      w_run;
    logic                      w_grant_en;
    logic [N_CH-1:0]           w_grant;
    logic [PTR_W-1:0]          w_gidx;
    logic                      w_gvalid;
    logic [N_CH-1:0]           w_load;
    logic [N_CH-1:0]           w_drop;
    logic [3:0]                w_drop_n;
    logic [PTR_W-1:0]          w_ptr_nxt;

    function automatic logic [DROP_CNT_WIDTH-1:0] sat_add(
        input logic [DROP_CNT_WIDTH-1:0] a,
        input logic [3:0]                b
    );
        logic [DROP_CNT_WIDTH:0] sum;
        sum = {1'b0, a} + (DROP_CNT_WIDTH+1)'(b);
        return sum[DROP_CNT_WIDTH] ? '1 : sum[DROP_CNT_WIDTH-1:0];
    endfunction

    assign w_run      = (r_state == S_RUN);
    // ALMOSTFULL gating absorbs the one-cycle lag of the registered write enable.
    assign w_grant_en = w_run && !fifo_full && !fifo_almost_full;

    rr_arbiter #(
        .N_CH  (N_CH),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .i_en    (w_grant_en),
        .i_req   (r_hold_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_valid (w_gvalid)
    );

    assign w_load    = w_run ? (ch_valid & (~r_hold_valid | w_grant)) : '0;
    assign w_drop    = w_run ? (ch_valid & r_hold_valid & ~w_grant) : '0;
    assign w_ptr_nxt = (w_gidx == PTR_W'(N_CH - 1)) ? '0 : w_gidx + 1'b1;

    always_comb begin
        w_drop_n = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_drop_n = w_drop_n + {3'b000, w_drop[i]};
        end
    end

    always_ff @(posedge Wclk or posedge rst) begin
        if (rst) begin
            r_state    <= S_RESET;
            r_cnt      <= '0;
            r_fifo_rst <= 1'b1;
        end else begin
            case (r_state)
                S_RESET: begin
                    if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
                        r_state    <= S_WAIT;
                        r_cnt      <= '0;
                        r_fifo_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == CNT_W'(RST_WAIT_CYCLES - 1)) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    r_state <= S_RUN;
                end
                default: begin
                    r_state    <= S_RESET;
                    r_cnt      <= '0;
                    r_fifo_rst <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge Wclk or posedge rst) begin
        if (rst) begin
            r_hold_valid <= '0;
            r_ptr        <= '0;
            r_wr_en      <= 1'b0;
            r_data       <= '0;
            r_drop_cnt   <= '0;
            r_ovf        <= '0;
            r_err        <= 1'b0;
        end else begin
            r_hold_valid <= (r_hold_valid & ~w_grant) | w_load;
            r_wr_en      <= w_gvalid;
            if (w_gvalid) begin
                r_data <= {CHW'(w_gidx), r_hold_data[w_gidx]};
                r_ptr  <= w_ptr_nxt;
            end
            // Same-cycle drops/errors land on top of the clear so none are lost.
            r_drop_cnt <= sat_add(clr_status ? '0 : r_drop_cnt, w_drop_n);
            r_ovf      <= (clr_status ? '0 : r_ovf) | w_drop;
            r_err      <= (clr_status ? 1'b0 : r_err) | (w_run & fifo_write_err);
        end
    end

    always_ff @(posedge Wclk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (w_load[i]) begin
                r_hold_data[i] <= ch_data[i*TS_WIDTH +: TS_WIDTH];
            end
        end
    end

    assign fifo_rst      = r_fifo_rst;
    assign fifo_wr_en    = r_wr_en;
    assign fifo_data     = r_data;
    assign ready         = w_run;
    assign drop_count    = r_drop_cnt;
    assign ch_overflow   = r_ovf;
    assign wr_err_sticky = r_err;

endmodule

// File: tb/tb_merge_write_arbiter.sv
// Randomized and directed stimulus for merge_write_arbiter, checked by a
// queue-based scoreboard fed from a transaction-level reference model.
module tb_merge_write_arbiter;

    localparam int N    = 4;
    localparam int TSW  = 28;
    localparam int RC   = 5;
    localparam int RW   = 8;
    localparam int DW   = 16;
    localparam int CHWT = 32 - TSW;
    localparam int DMAX = (1 << DW) - 1;

    logic              Wclk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      ch_valid = '0;
    logic [N*TSW-1:0]  ch_data = '0;
    logic              fifo_full = 1'b0;
    logic              fifo_almost_full = 1'b0;
    logic              fifo_write_err = 1'b0;
    logic              clr_status = 1'b0;
    logic              fifo_rst;
    logic              fifo_wr_en;
    logic [31:0]       fifo_data;
    logic              ready;
    logic [DW-1:0]     drop_count;
    logic [N-1:0]      ch_overflow;
    logic              wr_err_sticky;

    always #5 Wclk = ~Wclk;

    merge_write_arbiter #(
        .N_CH            (N),
        .TS_WIDTH        (TSW),
        .RST_CYCLES      (RC),
        .RST_WAIT_CYCLES (RW),
        .DROP_CNT_WIDTH  (DW)
    ) dut (
        .Wclk             (Wclk),
        .rst              (rst),
        .ch_valid         (ch_valid),
        .ch_data          (ch_data),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .fifo_write_err   (fifo_write_err),
        .clr_status       (clr_status),
        .fifo_rst         (fifo_rst),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_data        (fifo_data),
        .ready            (ready),
        .drop_count       (drop_count),
        .ch_overflow      (ch_overflow),
        .wr_err_sticky    (wr_err_sticky)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t q[$];

    // Reference model state: edges since reset release, per-channel holds.
    int            e = 0;
    int            n = 0;
    int            m_ptr = 0;
    bit            m_hv [N];
    logic [TSW-1:0] m_hd [N];
    logic [31:0]   m_data = '0;
    int            m_cnt = 0;
    bit [N-1:0]    m_ov = '0;
    bit            m_err = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit run;
        int g;
        int drops;
        bit [N-1:0] dmask;
        run   = (n >= RC + RW);
        g     = -1;
        drops = 0;
        dmask = '0;
        if (run && !fifo_full && !fifo_almost_full) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && m_hv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        if (g >= 0) begin
            m_data = {CHWT'(g), m_hd[g]};
            q.push_back('{data: m_data, due: e + 1});
            m_ptr  = (g + 1) % N;
            m_hv[g] = 1'b0;
        end
        if (run) begin
            for (int i = 0; i < N; i++) begin
                if (ch_valid[i]) begin
                    if (!m_hv[i]) begin
                        m_hv[i] = 1'b1;
                        m_hd[i] = ch_data[i*TSW +: TSW];
                    end else begin
                        drops++;
                        dmask[i] = 1'b1;
                    end
                end
            end
        end
        if (clr_status) begin
            m_cnt = 0;
            m_ov  = '0;
            m_err = 1'b0;
        end
        m_cnt = (m_cnt + drops > DMAX) ? DMAX : m_cnt + drops;
        m_ov  = m_ov | dmask;
        if (run && fifo_write_err) m_err = 1'b1;
        e++;
        n++;
    endtask

    initial begin
        forever begin
            @(posedge Wclk or posedge rst);
            if (rst) begin
                n      = 0;
                m_ptr  = 0;
                m_data = '0;
                m_cnt  = 0;
                m_ov   = '0;
                m_err  = 1'b0;
                for (int i = 0; i < N; i++) m_hv[i] = 1'b0;
                q.delete();
            end else begin
                model_edge();
            end
        end
    end

    // Monitor: every falling edge, compare all outputs against the model.
    initial begin
        forever begin
            bit exp_we;
            @(negedge Wclk);
            chk("fifo_rst", {31'b0, fifo_rst}, {31'b0, (rst || n < RC)});
            chk("ready", {31'b0, ready}, {31'b0, (!rst && n >= RC + RW)});
            exp_we = (q.size() > 0) && (q[0].due == e);
            chk("wr_en", {31'b0, fifo_wr_en}, {31'b0, exp_we});
            if (exp_we) begin
                chk("wr_data", fifo_data, q[0].data);
                void'(q.pop_front());
            end
            chk("fifo_data_hold", fifo_data, m_data);
            chk("drop_count", {16'b0, drop_count}, m_cnt);
            chk("ch_overflow", {28'b0, ch_overflow}, {28'b0, m_ov});
            chk("wr_err_sticky", {31'b0, wr_err_sticky}, {31'b0, m_err});
        end
    end

    task automatic tick();
        @(posedge Wclk);
        #1;
    endtask

    task automatic wait_ready(input string nm);
        for (int i = 0; i < 50 && !ready; i++) tick();
        if (!ready) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: ready not seen within 50 cycles", nm);
        end
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < N; i++) begin
            ch_valid[i] = ($urandom_range(0, 9) < 3);
            ch_data[i*TSW +: TSW] = TSW'($urandom);
        end
        fifo_almost_full = ($urandom_range(0, 9) == 0);
        fifo_full        = ($urandom_range(0, 19) == 0);
        fifo_write_err   = ($urandom_range(0, 49) == 0);
        clr_status       = ($urandom_range(0, 99) == 0);
    endtask

    task automatic idle_inputs();
        ch_valid = '0;
        fifo_almost_full = 1'b0;
        fifo_full = 1'b0;
        fifo_write_err = 1'b0;
        clr_status = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;

        // Strobe during the recovery window must be ignored.
        repeat (7) tick();
        ch_valid = 4'b0001;
        ch_data[0 +: TSW] = 28'h1234567;
        tick();
        ch_valid = '0;
        wait_ready("ready_after_reset");
        chk("no_drop_in_wait", {16'b0, drop_count}, 32'd0);
        tick();

        ch_valid = 4'b0100;
        ch_data[2*TSW +: TSW] = 28'h0ABCDEF;
        tick();
        ch_valid = '0;
        tick();
        chk("single_hit_we", {31'b0, fifo_wr_en}, 32'd1);
        chk("single_hit_data", fifo_data, 32'h20ABCDEF);
        repeat (3) tick();

        for (int i = 0; i < N; i++) ch_data[i*TSW +: TSW] = TSW'(i + 1);
        ch_valid = 4'b1111;
        tick();
        ch_valid = '0;
        repeat (6) tick();
        ch_valid = 4'b0010;
        tick();
        ch_valid = '0;
        repeat (3) tick();
        ch_valid = 4'b1111;
        tick();
        ch_valid = '0;
        repeat (6) tick();

        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        fifo_almost_full = 1'b1;
        ch_valid = 4'b0010;
        for (int j = 0; j < 10; j++) begin
            ch_data[TSW +: TSW] = TSW'(32'h100 + j);
            tick();
        end
        chk("bp_drop_count", {16'b0, drop_count}, 32'd9);
        chk("bp_overflow", {28'b0, ch_overflow}, 32'b0010);
        chk("bp_no_write", {31'b0, fifo_wr_en}, 32'd0);
        fifo_almost_full = 1'b0;
        ch_valid = '0;
        repeat (4) tick();

        fifo_almost_full = 1'b1;
        ch_valid = 4'b1000;
        tick();
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        ch_valid = '0;
        chk("clr_drop_count", {16'b0, drop_count}, 32'd1);
        chk("clr_overflow", {28'b0, ch_overflow}, 32'b1000);
        fifo_almost_full = 1'b0;
        repeat (4) tick();

        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            tick();
        end
        idle_inputs();
        repeat (8) tick();

        ch_valid = 4'b0111;
        for (int i = 0; i < N; i++) ch_data[i*TSW +: TSW] = TSW'(32'hDEAD0 + i);
        tick();
        ch_valid = '0;
        tick();
        chk("pre_reset_we", {31'b0, fifo_wr_en}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_reset_we", {31'b0, fifo_wr_en}, 32'd0);
        chk("mid_reset_fifo_rst", {31'b0, fifo_rst}, 32'd1);
        tick();
        rst = 1'b0;
        wait_ready("ready_after_mid_reset");
        for (int c = 0; c < 500; c++) begin
            rand_inputs();
            tick();
        end
        idle_inputs();
        repeat (8) tick();

        fifo_almost_full = 1'b1;
        ch_valid = 4'b1111;
        for (int c = 0; c < 16400; c++) tick();
        chk("sat_drop_count", {16'b0, drop_count}, 32'h0000FFFF);
        idle_inputs();
        repeat (10) tick();

        chk("scoreboard_empty", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
